// File: rtl/m2v_byte_unpacker.sv
`default_nettype none
// ============================================================================
// m2v_byte_unpacker : buffers 256-bit MPEG2 stream words and emits them MSB
// byte first over valid/ready, flagging start codes and counting pictures.
// Revision: 1.0
// ============================================================================
module m2v_byte_unpacker #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_last,
  input  logic [255:0] i_data,
  output logic         o_overflow,
  output logic         o_en,
  input  logic         i_ready,
  output logic [7:0]   o_data,
  output logic         o_last,
  output logic         o_sc_en,
  output logic [15:0]  o_pic_count,
  output logic [31:0]  o_byte_count,
  output logic [31:0]  o_seq_bytes
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [0:0]      S_EMPTY  = 1'b0;
  localparam logic [0:0]      S_SHIFT  = 1'b1;

  logic [256:0]  mem_q [DEPTH];
  logic [256:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [0:0]    state_q, state_d;
  logic [255:0]  word_q, word_d;
  logic          last_q, last_d;
  logic [4:0]    idx_q, idx_d;
  logic [23:0]   hist_q, hist_d;
  logic [1:0]    hist_cnt_q, hist_cnt_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   pic_q, pic_d;
  logic [31:0]   bytes_q, bytes_d;
  logic [31:0]   seq_q, seq_d;

  logic fifo_empty, at_end, xfer, pop, push;

  assign fifo_empty = (count_q == '0);
  assign at_end     = (idx_q == 5'd31);
  assign xfer       = o_en & i_ready;
  // Reloading on the final byte's transfer keeps word boundaries bubble-free.
  assign pop        = !fifo_empty && ((state_q == S_EMPTY) || (xfer && at_end));
  assign push       = i_en && ((count_q != FULL_CNT) || pop);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (pop) state_d = S_SHIFT;
      S_SHIFT: if (xfer && at_end && !pop) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    o_en    = (state_q == S_SHIFT);
    o_data  = o_en ? word_q[255:248] : 8'h00;
    o_last  = o_en && last_q && at_end;
    o_sc_en = o_en && (hist_cnt_q == 2'd3) && (hist_q == 24'h000001);
  end

  assign o_overflow   = overflow_q;
  assign o_pic_count  = pic_q;
  assign o_byte_count = bytes_q;
  assign o_seq_bytes  = seq_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {i_last, i_data};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | (i_en & ~push);
  end

  // The holding register shifts left so the current byte is always at the top.
  always_comb begin
    word_d = word_q;
    last_d = last_q;
    idx_d  = idx_q;
    if (pop) begin
      word_d = mem_q[rd_ptr_q][255:0];
      last_d = mem_q[rd_ptr_q][256];
      idx_d  = 5'd0;
    end else if (xfer) begin
      word_d = {word_q[247:0], 8'h00};
      idx_d  = idx_q + 5'd1;
    end
  end

  always_comb begin
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    pic_d      = pic_q;
    bytes_d    = bytes_q;
    seq_d      = seq_q;
    if (xfer) begin
      if (o_last) begin
        hist_d     = 24'h0;
        hist_cnt_d = 2'd0;
        seq_d      = bytes_q + 32'd1;
        bytes_d    = 32'd0;
        pic_d      = 16'd0;
      end else begin
        hist_d  = {hist_q[15:0], o_data};
        bytes_d = bytes_q + 32'd1;
        if (hist_cnt_q != 2'd3) hist_cnt_d = hist_cnt_q + 2'd1;
        if (o_sc_en && (o_data == 8'h00) && (pic_q != 16'hFFFF)) pic_d = pic_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_EMPTY;
      word_q     <= '0;
      last_q     <= 1'b0;
      idx_q      <= 5'd0;
      hist_q     <= 24'h0;
      hist_cnt_q <= 2'd0;
      overflow_q <= 1'b0;
      pic_q      <= 16'd0;
      bytes_q    <= 32'd0;
      seq_q      <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      word_q     <= word_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
      overflow_q <= overflow_d;
      pic_q      <= pic_d;
      bytes_q    <= bytes_d;
      seq_q      <= seq_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m2v_byte_unpacker.sv
`default_nettype none
// ============================================================================
// tb_m2v_byte_unpacker : directed self-checking bench for m2v_byte_unpacker.
// Revision: 1.0
// ============================================================================
module tb_m2v_byte_unpacker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_en = 1'b0;
  logic         i_last = 1'b0;
  logic [255:0] i_data = '0;
  logic         i_ready = 1'b0;
  logic         o_overflow, o_en, o_last, o_sc_en;
  logic [7:0]   o_data;
  logic [15:0]  o_pic_count;
  logic [31:0]  o_byte_count, o_seq_bytes;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_b[$];
  logic       exp_l[$];
  logic       exp_sc[$];

  m2v_byte_unpacker #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_last(i_last), .i_data(i_data),
    .o_overflow(o_overflow), .o_en(o_en), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .o_sc_en(o_sc_en), .o_pic_count(o_pic_count),
    .o_byte_count(o_byte_count), .o_seq_bytes(o_seq_bytes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [255:0] mk(input logic [7:0] base);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[255-8*i -: 8] = base + 8'(i);
    return w;
  endfunction

  task automatic enq_word(input logic [255:0] w, input logic last, input logic [31:0] sc_mask);
    for (int i = 0; i < 32; i++) begin
      exp_b.push_back(w[255-8*i -: 8]);
      exp_l.push_back(last && (i == 31));
      exp_sc.push_back(sc_mask[i]);
    end
  endtask

  task automatic push(input logic [255:0] w, input logic last);
    i_en = 1'b1; i_data = w; i_last = last;
    @(negedge clk);
    i_en = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_en(input int budget);
    int c = 0;
    while (!o_en && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_en", 32'(o_en), 32'd1);
  endtask

  // Checks the presented byte every valid cycle (so holds are verified too)
  // and consumes an expected entry only on a transfer.
  task automatic drain(input int n, input bit toggle, input int budget, output int cyc);
    int got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      i_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (o_en) begin
        if (exp_b.size() == 0) begin
          chk("extra_byte", 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          chk("data", 32'(o_data), 32'(exp_b[0]));
          chk("last", 32'(o_last), 32'(exp_l[0]));
          chk("sc_en", 32'(o_sc_en), 32'(exp_sc[0]));
          if (i_ready) begin
            void'(exp_b.pop_front());
            void'(exp_l.pop_front());
            void'(exp_sc.pop_front());
            got++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain_count", 32'(got), 32'(n));
  endtask

  initial begin
    int cyc;
    logic [255:0] w;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_en", 32'(o_en), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_bytes", o_byte_count, 32'd0);
    chk("rst_pic", 32'(o_pic_count), 32'd0);
    chk("rst_seq", o_seq_bytes, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word 00..1F, two-cycle latency
    i_ready = 1'b1;
    w = mk(8'h00);
    enq_word(w, 1'b1, 32'h0);
    push(w, 1'b1);
    chk("lat_en_early", 32'(o_en), 32'd0);
    @(negedge clk);
    chk("lat_en", 32'(o_en), 32'd1);
    chk("lat_byte0", 32'(o_data), 32'h00);
    drain(32, 1'b0, 40, cyc);
    chk("t1_cycles", 32'(cyc), 32'd32);
    chk("t1_idle", 32'(o_en), 32'd0);
    chk("t1_seq", o_seq_bytes, 32'd32);
    chk("t1_bytes", o_byte_count, 32'd0);

    // Start codes at bytes 3, 11, 23; two picture codes
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      case (i)
        0, 1, 8, 9, 11, 20, 21, 23: b = 8'h00;
        2, 10, 22:                  b = 8'h01;
        3:                          b = 8'hB3;
        default:                    b = 8'hAA;
      endcase
      w[255-8*i -: 8] = b;
    end
    i_ready = 1'b0;
    enq_word(w, 1'b1, 32'h0080_0808);
    push(w, 1'b1);
    wait_en(5);
    drain(31, 1'b0, 40, cyc);
    chk("t2_pic_before_last", 32'(o_pic_count), 32'd2);
    chk("t2_bytes_before_last", o_byte_count, 32'd31);
    drain(1, 1'b0, 5, cyc);
    chk("t2_pic_after", 32'(o_pic_count), 32'd0);
    chk("t2_seq", o_seq_bytes, 32'd32);

    // Three back-to-back words, no bubbles
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w = mk(8'(8'h80 + 32 * k));
      enq_word(w, (k == 2), 32'h0);
      push(w, (k == 2));
    end
    wait_en(5);
    drain(96, 1'b0, 120, cyc);
    chk("t3_cycles", 32'(cyc), 32'd96);
    chk("t3_seq", o_seq_bytes, 32'd96);
    chk("t3_idle", 32'(o_en), 32'd0);

    // Ready toggling 1,0,1,0...
    i_ready = 1'b0;
    w = mk(8'h20);
    enq_word(w, 1'b1, 32'h0);
    push(w, 1'b1);
    wait_en(5);
    drain(32, 1'b1, 80, cyc);
    chk("t4_cycles", 32'(cyc), 32'd63);

    // Overflow: five accepted, sixth dropped
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = mk(8'(32 * (k + 1)));
      enq_word(w, (k == 4), 32'h0);
      push(w, (k == 4));
    end
    chk("t5_ovf_before", 32'(o_overflow), 32'd0);
    push({32{8'hEE}}, 1'b1);
    chk("t5_ovf_set", 32'(o_overflow), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_ovf_sticky", 32'(o_overflow), 32'd1);
    drain(160, 1'b0, 200, cyc);
    chk("t5_cycles", 32'(cyc), 32'd160);
    @(negedge clk);
    chk("t5_idle", 32'(o_en), 32'd0);
    chk("t5_seq", o_seq_bytes, 32'd160);
    chk("t5_ovf_end", 32'(o_overflow), 32'd1);

    // Reset mid-word
    i_ready = 1'b0;
    w = mk(8'h50);
    enq_word(w, 1'b1, 32'h0);
    push(w, 1'b1);
    wait_en(5);
    drain(10, 1'b0, 20, cyc);
    chk("t6_bytes_pre", o_byte_count, 32'd10);
    i_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_en", 32'(o_en), 32'd0);
    chk("t6_bytes", o_byte_count, 32'd0);
    chk("t6_pic", 32'(o_pic_count), 32'd0);
    chk("t6_seq", o_seq_bytes, 32'd0);
    chk("t6_ovf", 32'(o_overflow), 32'd0);
    rst = 1'b0;
    exp_b.delete();
    exp_l.delete();
    exp_sc.delete();
    @(negedge clk);
    chk("t6_still_idle", 32'(o_en), 32'd0);
    w = mk(8'h60);
    enq_word(w, 1'b1, 32'h0);
    push(w, 1'b1);
    wait_en(5);
    drain(32, 1'b0, 40, cyc);
    chk("t6_seq_new", o_seq_bytes, 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
